// File: rtl/coax_pkg.sv
// coax_pkg: shared constants for the buffered 3270 coax transmitter.
// Sequencer state codes, frame field lengths and bi-phase helpers.
package coax_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_QUIESCE = 3'd1;
  localparam logic [2:0] S_CODE_VIOLATION = 3'd2;
  localparam logic [2:0] S_SYNC = 3'd3;
  localparam logic [2:0] S_DATA = 3'd4;
  localparam logic [2:0] S_PARITY = 3'd5;
  localparam logic [2:0] S_END = 3'd6;

  localparam int QUIESCE_BITS = 5;
  localparam int CV_BIT_TIMES = 3;
  localparam int DATA_BITS = 10;

  // "1" is low then high, "0" is high then low.
  function automatic logic biphase(
    input logic b,
    input logic first_half
  );
    return b ? !first_half : first_half;
  endfunction

  function automatic logic even_parity(
    input logic [DATA_BITS-1:0] w
  );
    return ^w;
  endfunction

endpackage

// File: rtl/coax_tx_fifo.sv
// coax_tx_fifo: synchronous word FIFO with count, full and empty.
// Writes while full are dropped; pointers wrap modulo DEPTH.
module coax_tx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] wdata,
  input  logic             push,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] count;
  logic wr_ok;
  logic rd_ok;

  assign full = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign wr_ok = push && !full;
  assign rd_ok = pop && !empty;
  assign rdata = mem[rptr];

  // Storage array, written only on accepted pushes.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= wdata;
    end
  end

  // Pointer advance; power-of-two depth wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
      end
    end
  end

  // Occupancy; simultaneous push and pop leave it unchanged.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else begin
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/coax_buffered_tx.sv
// coax_buffered_tx: buffered 3270 coax bi-phase frame transmitter.
// Define COAX_TX_OVERFLOW_ERROR_EN to enable the overflow error pulse.
module coax_buffered_tx
  import coax_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = 16,
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] data,
  input  logic       load_strobe,
  output logic       tx,
  output logic       active,
  output logic       full,
  output logic       empty,
  output logic       error
);

  localparam int TW = $clog2(CLOCKS_PER_BIT);
  localparam logic [TW-1:0] T_LAST = TW'(CLOCKS_PER_BIT - 1);
  localparam logic [TW-1:0] T_HALF = TW'(CLOCKS_PER_BIT / 2);
  localparam logic [3:0] Q_LAST = 4'(QUIESCE_BITS - 1);
  localparam logic [3:0] CV_LAST = 4'(CV_BIT_TIMES - 1);
  localparam logic [3:0] D_LAST = 4'(DATA_BITS - 1);

  logic [2:0] state;
  logic [2:0] state_next;
  logic [TW-1:0] bit_timer;
  logic [3:0] bit_count;
  logic [DATA_BITS-1:0] shreg;
  logic par;
  logic bit_end;
  logic first_half;
  logic pop;
  logic [DATA_BITS-1:0] rdata;

  coax_tx_fifo #(
    .WIDTH(DATA_BITS),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .wdata(data),
    .push (load_strobe),
    .pop  (pop),
    .rdata(rdata),
    .full (full),
    .empty(empty)
  );

  assign bit_end = (bit_timer == T_LAST);
  assign first_half = (bit_timer < T_HALF);
  assign pop = (state == S_SYNC) &&
               (bit_count == 4'd0) &&
               (bit_timer == '0);
  assign active = (state != S_IDLE);

  // Frame sequencer next-state decode.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (!empty) state_next = S_QUIESCE;
      end
      S_QUIESCE: begin
        if (bit_end && bit_count == Q_LAST)
          state_next = S_CODE_VIOLATION;
      end
      S_CODE_VIOLATION: begin
        if (bit_end && bit_count == CV_LAST)
          state_next = S_SYNC;
      end
      S_SYNC: begin
        if (bit_end) state_next = S_DATA;
      end
      S_DATA: begin
        if (bit_end && bit_count == D_LAST)
          state_next = S_PARITY;
      end
      S_PARITY: begin
        if (bit_end)
          state_next = empty ? S_END : S_SYNC;
      end
      S_END: begin
        if (bit_end && bit_count == 4'd1)
          state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register; reset aborts any frame in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Bit timing; both counters restart on every state change.
  always_ff @(posedge clk) begin
    if (reset) begin
      bit_timer <= '0;
      bit_count <= '0;
    end else if (state_next != state || state == S_IDLE) begin
      bit_timer <= '0;
      bit_count <= '0;
    end else if (bit_end) begin
      bit_timer <= '0;
      bit_count <= bit_count + 4'd1;
    end else begin
      bit_timer <= bit_timer + TW'(1);
    end
  end

  // Word latch at SYNC entry, MSB-first shift through DATA.
  always_ff @(posedge clk) begin
    if (reset) begin
      shreg <= '0;
      par <= 1'b0;
    end else if (pop) begin
      shreg <= rdata;
      par <= even_parity(rdata);
    end else if (state == S_DATA && bit_end) begin
      shreg <= {shreg[DATA_BITS-2:0], 1'b0};
    end
  end

  // Line encoder.
  always_comb begin
    tx = 1'b0;
    case (state)
      S_QUIESCE: tx = biphase(1'b1, first_half);
      S_CODE_VIOLATION: begin
        tx = (bit_count == 4'd0) ||
             (bit_count == 4'd1 && first_half);
      end
      S_SYNC:   tx = biphase(1'b1, first_half);
      S_DATA:   tx = biphase(shreg[DATA_BITS-1], first_half);
      S_PARITY: tx = biphase(par, first_half);
      S_END: begin
        tx = (bit_count == 4'd0) ?
             biphase(1'b0, first_half) : 1'b1;
      end
      default:  tx = 1'b0;
    endcase
  end

`ifdef COAX_TX_OVERFLOW_ERROR_EN
  logic error_q;

  // One-cycle pulse after a write that arrived while full.
  always_ff @(posedge clk) begin
    if (reset) begin
      error_q <= 1'b0;
    end else begin
      error_q <= load_strobe && full;
    end
  end

  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: doc/coax_buffered_tx.md
Name: coax_buffered_tx

Overview:
Buffered 3270 coax transmitter; sits between `control` (upstream, which writes 10-bit words) and the coax line driver (downstream).
- Accepts words into a FIFO.
- Frames them as: line quiesce, code violation, words, end sequence.
- Bi-phase encodes every bit.
- A frame keeps running while the FIFO has data and closes when it drains.

Parameters:
CLOCKS_PER_BIT, 16, clk cycles per bit time; even, >=4; half-bit = CLOCKS_PER_BIT/2.
DEPTH, 16, FIFO depth in words; power of two, >=2.

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
data  input  10  word to transmit.
load_strobe  input  1  one-cycle write of data into the FIFO.
tx  output  1  bi-phase encoded line output.
active  output  1  high for the whole frame, first quiesce bit through end sequence.
full  output  1  FIFO count == DEPTH.
empty  output  1  FIFO count == 0.
error  output  1  one-cycle overflow pulse (see Optional Feature).

Behaviour:
Interface: one clock `clk`; reset is synchronous, active-high, port `reset`.

Reset values:
- tx=0, active=0, full=0, empty=1, error=0.
- FIFO cleared; state IDLE.
- Reset mid-frame: frame aborted, tx=0 from the next cycle, no end sequence sent.

Bit encoding (each half is CLOCKS_PER_BIT/2 cycles):
- "1" = low half, then high half.
- "0" = high half, then low half.

States and transitions:
- IDLE: tx=0. Leaves when !empty: next cycle goes to QUIESCE, active=1.
- QUIESCE: 5 "1" bits -> CODE_VIOLATION.
- CODE_VIOLATION: tx high for 1.5 bit times, then low for 1.5 bit times (3 bit times) -> SYNC.
- SYNC: FIFO pops on the first cycle of SYNC and the word is latched into the shift register. Sends "1" -> DATA.
- DATA: 10 bits, MSB (bit 9) first -> PARITY.
- PARITY: even parity bit = XOR of data[9:0]. At the last cycle of PARITY: !empty -> SYNC; empty -> END.
- END: one "0" bit, then tx high for 1 bit time -> IDLE. tx=0 and active=0 on the IDLE entry cycle.

Frame length: (5 + 3 + 12·N + 2) bit times for N words.

FIFO rules:
- Write is accepted when !full, counted on registered state. A write while full is dropped, even if a pop occurs in the same cycle.
- A write coinciding with a pop when not full: both take effect; count unchanged.
- full/empty update the cycle after the write or pop.
- A word loaded at any point before the last cycle of PARITY joins the current frame.
- Read/write pointers wrap modulo DEPTH; count width is clog2(DEPTH)+1.

Latency: load_strobe at cycle T into an empty, idle block gives empty=0 at T+1 and active=1 plus the first quiesce half-bit at T+2.

Counters: bit_timer counts 0..CLOCKS_PER_BIT-1; bit_count is sized for 10 bits; both clear on every state change.

Optional Feature:
Macro COAX_TX_OVERFLOW_ERROR_EN.
- Defined: error pulses high for exactly one cycle, the cycle after a dropped write. The pulse is not sticky.
- Undefined: error tied to 0; dropped writes are silent. All other behaviour is identical.

Decomposition:
Shared package coax_pkg holds:
- tx state encoding (IDLE, QUIESCE, CODE_VIOLATION, SYNC, DATA, PARITY, END).
- QUIESCE_BITS=5, CV_BIT_TIMES=3, DATA_BITS=10.

Sub-module coax_tx_fifo: synchronous FIFO with count, full, empty, wrap logic; no sequencer knowledge. The top level contains the sequencer, shift register, parity and encoder.

Test Plan (CLOCKS_PER_BIT=8, DEPTH=4):
1. Assert reset 3 cycles -> tx=0, active=0, empty=1, full=0, error=0.
2. Load 10'h2A5 once -> five "1"s, CV (12 high / 12 low), sync 1, bits 1010100101, parity 1, "0" then 8 cycles high. active high 176 cycles, empty=0 for 1 cycle before active.
3. Load 10'h000 then 10'h3FF back-to-back -> both in one frame, parity 0 for each, no end sequence between, active 272 cycles.
4. Hold sequencer by loading 5 words in 5 consecutive cycles -> full=1 after 4th; 5th dropped, error pulses 1 cycle with COAX_TX_OVERFLOW_ERROR_EN, stays 0 without; exactly 4 words transmitted.
5. Reset asserted mid-DATA of word 1 -> tx=0 and active=0 next cycle, empty=1, no further transitions.
6. Load 10'h155 during the last PARITY bit of an in-flight word -> SYNC follows directly, 10'h155 appended to the same frame.
